risc_stage_sequencer: RTL and testbench
=======================================

Name: risc_stage_sequencer

Overview:
- Multi-cycle control FSM for the KGPRISC datapath.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB, as required by the instruction class.
- Drives the datapath write enables and memory strobes, and enforces a memory-wait timeout.
- Advances only on cycles with step_en=1, so the processor runs from the fast clock gated by the slow-clock tick.

Parameters:
- WAIT_MAX, 15: maximum step_en cycles spent waiting on mem_ready in FETCH or MEM before a fault. Range 1..255.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; forces all state to reset values.
- step_en  in  1  advance enable (slow-clock tick); FSM holds when 0.
- op_class  in  3  decoded class of the current IR, sampled in DECODE. 0=ALU, 1=LOAD, 2=STORE, 3=BRANCH, 4=HALT, 5..7=illegal.
- branch_taken  in  1  branch condition from ALU flags, sampled in EXEC.
- mem_ready  in  1  memory access complete this cycle.
- mem_re  out  1  memory read request (level).
- mem_we  out  1  memory write request (level).
- ir_we  out  1  instruction register load (pulse).
- pc_we  out  1  PC update (pulse).
- pc_sel  out  1  0=PC+4, 1=branch target; valid when pc_we=1.
- alu_en  out  1  ALU operand/result latch enable (level).
- rf_we  out  1  register file write (pulse).
- instr_done  out  1  instruction retired (pulse).
- illegal_op  out  1  illegal class seen (pulse).
- mem_err  out  1  sticky memory timeout flag.
- halted  out  1  FSM in HALTED.
- stage  out  3  current state code.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=7. Codes 5 and 6 are unreachable; if entered, go to FETCH on the next clock.
- Reset value of the state is FETCH.
- While reset=1, every output is 0, except stage=0.
- Reset also clears the class register, wait counter, mem_err and instr_count.
- Reset asserted mid-instruction abandons the instruction; no pulse is emitted.
- Pulse outputs are combinational from (state, step_en, inputs) and are high only in the cycle of the state transition. Zero latency.
- Level outputs depend on state only.
- FETCH:
  - mem_re=1.
  - step_en & mem_ready: ir_we=1, pc_we=1, pc_sel=0; go to DECODE.
- DECODE:
  - On step_en, latch op_class into the internal class register.
  - Class 4 goes to HALTED.
  - Classes 5..7 go to FETCH with illegal_op=1; these are not counted.
  - All other classes go to EXEC.
- EXEC:
  - alu_en=1.
  - On step_en: ALU goes to WB; LOAD and STORE go to MEM.
  - BRANCH goes to FETCH with instr_done=1. If branch_taken=1, also pc_we=1 and pc_sel=1.
- MEM:
  - mem_re=1 for LOAD; mem_we=1 for STORE.
  - step_en & mem_ready: LOAD goes to WB; STORE goes to FETCH with instr_done=1.
- WB:
  - On step_en: rf_we=1, instr_done=1; go to FETCH.
- HALTED:
  - halted=1; all strobes 0.
  - Held until reset. A HALT instruction does not pulse instr_done.
- Wait counter (8 bits):
  - Cleared on entering FETCH or MEM.
  - Increments on each step_en cycle in FETCH or MEM with mem_ready=0.
  - If step_en & !mem_ready and the counter equals WAIT_MAX-1: set mem_err=1 and go to HALTED.
  - mem_ready in the same cycle as the limit wins; no fault.
- instr_count increments by 1 on instr_done and wraps from 2^CNT_W-1 to 0.
- Input changes while step_en=0 have no effect on state or counters.

Test Plan:
- ALU instruction: reset, mem_ready=1, step_en=1 every cycle, op_class=0. Stage sequence 0,1,2,4,0; one ir_we, one pc_we, one rf_we; instr_count=1 after 4 cycles.
- LOAD with memory stall: op_class=1, mem_ready=0 for 3 step_en cycles in MEM. Stage stays 3 for 3 cycles with mem_re=1; then WB with rf_we=1; instr_count=1. STORE variant: mem_we=1 in MEM, no rf_we, 4 cycles total with mem_ready=1.
- BRANCH: op_class=3. With branch_taken=1, EXEC pulses pc_we=1 and pc_sel=1. With branch_taken=0, no second pc_we. instr_done=1 in both cases.
- Timeout: WAIT_MAX=4, mem_ready held 0 in FETCH. After 4 step_en cycles, mem_err=1, halted=1, stage=7; stays halted for 20 more cycles. With mem_ready=1 on the 4th cycle instead, DECODE is reached and mem_err=0.
- Halt and illegal: op_class=6 gives illegal_op pulse, return to FETCH, instr_count unchanged. op_class=4 gives halted=1 with no instr_done.
- step_en gating and reset: step_en toggling 1 of every 4 cycles gives the same stage sequence at a quarter rate. Asserting reset in MEM for 1 ns asynchronously forces stage=0, all strobes 0 and instr_count=0. Set CNT_W=2 and retire 5 ALU instructions: instr_count=1.

Source files
------------

// File: rtl/risc_stage_sequencer.sv
// risc_stage_sequencer
// Multi-cycle control FSM for the KGPRISC datapath. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB as its class requires, advancing only on
// step_en ticks. It drives the datapath strobes and stops with a sticky
// mem_err if memory fails to answer within WAIT_MAX ticks.
module risc_stage_sequencer #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_en,
  input  logic [2:0]       op_class,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_re,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             alu_en,
  output logic             rf_we,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_err,
  output logic             halted,
  output logic [2:0]       stage,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd7
  } state_t;

  localparam logic [2:0] CL_ALU    = 3'd0;
  localparam logic [2:0] CL_LOAD   = 3'd1;
  localparam logic [2:0] CL_STORE  = 3'd2;
  localparam logic [2:0] CL_BRANCH = 3'd3;
  localparam logic [2:0] CL_HALT   = 3'd4;

  // The fault fires on the tick where the counter has already seen
  // WAIT_MAX-1 unanswered ticks, i.e. the WAIT_MAX-th unanswered tick.
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX - 1);

  state_t           state_reg, state_next;
  logic [2:0]       class_reg, class_next;
  logic [7:0]       wait_reg, wait_next;
  logic             mem_err_reg, mem_err_next;
  logic [CNT_W-1:0] count_reg, count_next;

  // Unqualified strobes; gated by reset below so nothing leaks while in reset.
  logic re_c, we_c, ir_c, pc_c, sel_c, alu_c, rf_c, done_c, ill_c, halt_c;
  logic timeout;

  assign timeout = step_en && !mem_ready && (wait_reg == WAIT_LIM);

  // State, class, wait counter, error flag and retire counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_FETCH;
      class_reg   <= 3'd0;
      wait_reg    <= 8'd0;
      mem_err_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      class_reg   <= class_next;
      wait_reg    <= wait_next;
      mem_err_reg <= mem_err_next;
      count_reg   <= count_next;
    end
  end

  // Next-state, counter updates and strobe decode.
  always_comb begin
    state_next   = state_reg;
    class_next   = class_reg;
    wait_next    = wait_reg;
    mem_err_next = mem_err_reg;
    re_c   = 1'b0;
    we_c   = 1'b0;
    ir_c   = 1'b0;
    pc_c   = 1'b0;
    sel_c  = 1'b0;
    alu_c  = 1'b0;
    rf_c   = 1'b0;
    done_c = 1'b0;
    ill_c  = 1'b0;
    halt_c = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        re_c = 1'b1;
        if (step_en) begin
          if (mem_ready) begin
            ir_c       = 1'b1;
            pc_c       = 1'b1;
            state_next = ST_DECODE;
          end else if (timeout) begin
            mem_err_next = 1'b1;
            state_next   = ST_HALTED;
          end else begin
            wait_next = wait_reg + 8'd1;
          end
        end
      end

      ST_DECODE: begin
        if (step_en) begin
          class_next = op_class;
          case (op_class)
            CL_ALU, CL_LOAD, CL_STORE, CL_BRANCH: state_next = ST_EXEC;
            CL_HALT:                              state_next = ST_HALTED;
            default: begin
              ill_c      = 1'b1;
              state_next = ST_FETCH;
            end
          endcase
        end
      end

      ST_EXEC: begin
        alu_c = 1'b1;
        if (step_en) begin
          case (class_reg)
            CL_ALU:            state_next = ST_WB;
            CL_LOAD, CL_STORE: state_next = ST_MEM;
            CL_BRANCH: begin
              done_c     = 1'b1;
              pc_c       = branch_taken;
              sel_c      = branch_taken;
              state_next = ST_FETCH;
            end
            default:           state_next = ST_FETCH;
          endcase
        end
      end

      ST_MEM: begin
        re_c = (class_reg == CL_LOAD);
        we_c = (class_reg == CL_STORE);
        if (step_en) begin
          if (mem_ready) begin
            if (class_reg == CL_LOAD) begin
              state_next = ST_WB;
            end else begin
              done_c     = (class_reg == CL_STORE);
              state_next = ST_FETCH;
            end
          end else if (timeout) begin
            mem_err_next = 1'b1;
            state_next   = ST_HALTED;
          end else begin
            wait_next = wait_reg + 8'd1;
          end
        end
      end

      ST_WB: begin
        if (step_en) begin
          rf_c       = 1'b1;
          done_c     = 1'b1;
          state_next = ST_FETCH;
        end
      end

      ST_HALTED: begin
        halt_c = 1'b1;
      end

      // Codes 5 and 6 recover unconditionally, without waiting for a tick.
      default: begin
        state_next = ST_FETCH;
      end
    endcase

    // Every fresh visit to a memory-waiting state starts its own budget.
    if ((state_next != state_reg) &&
        ((state_next == ST_FETCH) || (state_next == ST_MEM))) begin
      wait_next = 8'd0;
    end

    count_next = count_reg + CNT_W'(done_c);
  end

  assign mem_re      = !reset && re_c;
  assign mem_we      = !reset && we_c;
  assign ir_we       = !reset && ir_c;
  assign pc_we       = !reset && pc_c;
  assign pc_sel      = !reset && sel_c;
  assign alu_en      = !reset && alu_c;
  assign rf_we       = !reset && rf_c;
  assign instr_done  = !reset && done_c;
  assign illegal_op  = !reset && ill_c;
  assign halted      = !reset && halt_c;
  assign mem_err     = mem_err_reg;
  assign stage       = state_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_risc_stage_sequencer.sv
// Scoreboard bench for risc_stage_sequencer. The stimulus process drives one
// cycle of inputs and queues the hand-computed outputs for that cycle; the
// monitor pops and compares at the falling edge of the same cycle.
module tb_risc_stage_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       step_en = 1'b0;
  logic [2:0] op_class = 3'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_re, mem_we, ir_we, pc_we, pc_sel, alu_en, rf_we;
  logic       instr_done, illegal_op, mem_err, halted;
  logic [2:0] stage;
  logic [1:0] instr_count;

  // Signal vector order: re we ir pc sel alu rf done ill err halt
  localparam logic [10:0] RE = 11'h400;
  localparam logic [10:0] WE = 11'h200;
  localparam logic [10:0] IR = 11'h100;
  localparam logic [10:0] PC = 11'h080;
  localparam logic [10:0] PS = 11'h040;
  localparam logic [10:0] AL = 11'h020;
  localparam logic [10:0] RF = 11'h010;
  localparam logic [10:0] DN = 11'h008;
  localparam logic [10:0] IL = 11'h004;
  localparam logic [10:0] ER = 11'h002;
  localparam logic [10:0] HT = 11'h001;
  localparam logic [10:0] NONE = 11'h000;

  typedef struct packed {
    logic [2:0]  stg;
    logic [10:0] sig;
    logic [1:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  logic [1:0] exp_cnt = 2'd0;
  int checks = 0;
  int errors = 0;
  int txn = 0;

  risc_stage_sequencer #(.WAIT_MAX(4), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .step_en(step_en), .op_class(op_class),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_re(mem_re), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .alu_en(alu_en), .rf_we(rf_we),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_err(mem_err),
    .halted(halted), .stage(stage), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Monitor: compare the queued expectation against the live outputs.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [10:0] act, msk;
      e = exp_q.pop_front();
      act = {mem_re, mem_we, ir_we, pc_we, pc_sel, alu_en, rf_we,
             instr_done, illegal_op, mem_err, halted};
      // pc_sel is only meaningful while pc_we is expected high.
      msk = e.sig[7] ? 11'h7FF : ~PS;
      txn++;
      $display("txn %0d t=%0t stage %0d sig %03h cnt %0d", txn, $time, stage, act, instr_count);
      checks++;
      if (stage !== e.stg) begin
        errors++;
        $display("FAIL stage txn %0d got %0d want %0d", txn, stage, e.stg);
      end
      checks++;
      if ((act & msk) !== (e.sig & msk)) begin
        errors++;
        $display("FAIL strobes txn %0d got %03h want %03h", txn, act & msk, e.sig & msk);
      end
      checks++;
      if (instr_count !== e.cnt) begin
        errors++;
        $display("FAIL instr_count txn %0d got %0d want %0d", txn, instr_count, e.cnt);
      end
    end
  end

  task automatic cyc(input logic r, input logic se, input logic [2:0] oc,
                     input logic mr, input logic bt,
                     input logic [2:0] stg, input logic [10:0] sg);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; step_en = se; op_class = oc; mem_ready = mr; branch_taken = bt;
    e.stg = stg; e.sig = sg; e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    exp_cnt = 2'd0;
    cyc(1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 3'd0, NONE);
  endtask

  task automatic alu_instr();
    cyc(0, 1, 3'd0, 1, 0, 3'd0, RE | IR | PC);
    cyc(0, 1, 3'd0, 1, 0, 3'd1, NONE);
    cyc(0, 1, 3'd0, 1, 0, 3'd2, AL);
    cyc(0, 1, 3'd0, 1, 0, 3'd4, RF | DN);
    exp_cnt++;
  endtask

  initial begin
    // Reset state, with idle and with active inputs.
    cyc(1, 0, 3'd0, 0, 0, 3'd0, NONE);
    do_reset();

    // ALU instruction
    alu_instr();

    // LOAD with 3 stalled ticks in MEM
    cyc(0, 1, 3'd1, 1, 0, 3'd0, RE | IR | PC);
    cyc(0, 1, 3'd1, 1, 0, 3'd1, NONE);
    cyc(0, 1, 3'd1, 1, 0, 3'd2, AL);
    for (int k = 0; k < 3; k++) cyc(0, 1, 3'd1, 0, 0, 3'd3, RE);
    cyc(0, 1, 3'd1, 1, 0, 3'd3, RE);
    cyc(0, 1, 3'd1, 1, 0, 3'd4, RF | DN);
    exp_cnt++;

    // STORE
    cyc(0, 1, 3'd2, 1, 0, 3'd0, RE | IR | PC);
    cyc(0, 1, 3'd2, 1, 0, 3'd1, NONE);
    cyc(0, 1, 3'd2, 1, 0, 3'd2, AL);
    cyc(0, 1, 3'd2, 1, 0, 3'd3, WE | DN);
    exp_cnt++;

    // BRANCH taken, then not taken (count wraps 3->0->1)
    cyc(0, 1, 3'd3, 1, 0, 3'd0, RE | IR | PC);
    cyc(0, 1, 3'd3, 1, 0, 3'd1, NONE);
    cyc(0, 1, 3'd3, 1, 1, 3'd2, AL | PC | PS | DN);
    exp_cnt++;
    cyc(0, 1, 3'd3, 1, 0, 3'd0, RE | IR | PC);
    cyc(0, 1, 3'd3, 1, 0, 3'd1, NONE);
    cyc(0, 1, 3'd3, 1, 0, 3'd2, AL | DN);
    exp_cnt++;

    // Illegal class: pulse, back to FETCH, not counted
    cyc(0, 1, 3'd6, 1, 0, 3'd0, RE | IR | PC);
    cyc(0, 1, 3'd6, 1, 0, 3'd1, IL);

    // ALU at a quarter rate; inputs wiggle while step_en=0
    for (int k = 0; k < 3; k++) cyc(0, 0, 3'd4, 1, 1, 3'd0, RE);
    cyc(0, 1, 3'd0, 1, 0, 3'd0, RE | IR | PC);
    for (int k = 0; k < 3; k++) cyc(0, 0, 3'd4, 0, 1, 3'd1, NONE);
    cyc(0, 1, 3'd0, 1, 0, 3'd1, NONE);
    for (int k = 0; k < 3; k++) cyc(0, 0, 3'd3, 0, 1, 3'd2, AL);
    cyc(0, 1, 3'd0, 1, 0, 3'd2, AL);
    for (int k = 0; k < 3; k++) cyc(0, 0, 3'd6, 0, 0, 3'd4, NONE);
    cyc(0, 1, 3'd0, 1, 0, 3'd4, RF | DN);
    exp_cnt++;

    // Asynchronous 1 ns reset while a LOAD waits in MEM
    cyc(0, 1, 3'd1, 1, 0, 3'd0, RE | IR | PC);
    cyc(0, 1, 3'd1, 1, 0, 3'd1, NONE);
    cyc(0, 1, 3'd1, 1, 0, 3'd2, AL);
    cyc(0, 1, 3'd1, 0, 0, 3'd3, RE);
    begin
      exp_t e;
      @(posedge clk);
      #1;
      step_en = 1'b0; mem_ready = 1'b0;
      #1 reset = 1'b1;
      #1 reset = 1'b0;
      exp_cnt = 2'd0;
      e.stg = 3'd0; e.sig = RE; e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
    cyc(0, 0, 3'd0, 0, 0, 3'd0, RE);

    // Timeout in FETCH, then stuck in HALTED despite activity
    for (int k = 0; k < 4; k++) cyc(0, 1, 3'd0, 0, 0, 3'd0, RE);
    for (int k = 0; k < 20; k++) cyc(0, 1, 3'd0, 1, 0, 3'd7, ER | HT);
    do_reset();

    // Ready on the limit tick wins; then a LOAD whose MEM budget starts fresh
    for (int k = 0; k < 3; k++) cyc(0, 1, 3'd1, 0, 0, 3'd0, RE);
    cyc(0, 1, 3'd1, 1, 0, 3'd0, RE | IR | PC);
    cyc(0, 1, 3'd1, 1, 0, 3'd1, NONE);
    cyc(0, 1, 3'd1, 1, 0, 3'd2, AL);
    for (int k = 0; k < 3; k++) cyc(0, 1, 3'd1, 0, 0, 3'd3, RE);
    cyc(0, 1, 3'd1, 1, 0, 3'd3, RE);
    cyc(0, 1, 3'd1, 1, 0, 3'd4, RF | DN);
    exp_cnt++;

    // Timeout in MEM on a STORE
    cyc(0, 1, 3'd2, 1, 0, 3'd0, RE | IR | PC);
    cyc(0, 1, 3'd2, 1, 0, 3'd1, NONE);
    cyc(0, 1, 3'd2, 1, 0, 3'd2, AL);
    for (int k = 0; k < 4; k++) cyc(0, 1, 3'd2, 0, 0, 3'd3, WE);
    cyc(0, 1, 3'd2, 1, 0, 3'd7, ER | HT);
    do_reset();

    // HALT instruction: no instr_done, held in HALTED
    cyc(0, 1, 3'd4, 1, 0, 3'd0, RE | IR | PC);
    cyc(0, 1, 3'd4, 1, 0, 3'd1, NONE);
    for (int k = 0; k < 3; k++) cyc(0, 1, 3'd0, 1, 0, 3'd7, HT);
    do_reset();

    // Five ALU instructions with a 2-bit counter leave it at 1
    for (int k = 0; k < 5; k++) alu_instr();
    cyc(0, 0, 3'd0, 1, 0, 3'd0, RE);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
